drom_writer: RTL and testbench
==============================

Name: drom_writer

Overview:
- Write-side agent for the dual-port image memory; drives port A while the VGA path reads port B.
- Accepts an 8-bit pixel stream through a valid/ready handshake and packs four pixels into each 32-bit word.
- Writes each packed word to consecutive addresses starting at a base address latched on `start`.
- Signals completion after exactly FRAME_PIXELS pixels, so a processing core or loader can fill an image the display path then shows.

Parameters:
- ADDR_WIDTH, 32, width of port A address and of base_address.
- FRAME_PIXELS, 65536, pixels per frame load; must be >= 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; begins a frame load when idle.
- base_address  in  ADDR_WIDTH  word address of the first write; latched on an accepted start.
- pixel_in  in  8  pixel data.
- pixel_valid  in  1  pixel_in is valid this cycle.
- pixel_ready  out  1  block accepts a pixel this cycle.
- address_a  out  ADDR_WIDTH  port A word address.
- data_a  out  32  port A write data.
- wren_a  out  1  port A write enable; one-cycle pulse per word.
- busy  out  1  high from an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last word has been written.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - State to IDLE.
  - All outputs 0, including address_a and data_a.
  - Pixel counter, lane index and word offset cleared.
  - The partial word is discarded.
  - Reset mid-frame aborts the load with no further writes.
- **States:** IDLE, LOAD, WRITE, DONE. All outputs are registered.
- **IDLE:**
  - pixel_ready=0, busy=0.
  - start=1: latch base_address, clear counters and the pack register, go to LOAD.
  - pixel_valid in IDLE is ignored; no pixel is consumed.
- **LOAD:**
  - pixel_ready=1, busy=1.
  - A pixel is accepted only when pixel_valid=1 and pixel_ready=1.
  - Packing is little-endian: the first pixel of a word goes to data bits [7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].
  - Go to WRITE when the 4th pixel of a word is accepted, or when the FRAME_PIXELS-th pixel of the frame is accepted, whichever comes first.
  - Unfilled lanes of a final partial word are written as 0.
- **WRITE** (exactly one cycle):
  - wren_a=1, pixel_ready=0.
  - address_a = latched base + word offset. Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
  - data_a holds the packed word.
  - Next cycle: go to DONE if the frame pixel count has been reached; otherwise clear the pack register, increment the word offset and return to LOAD.
- **Port A hold:** wren_a=0 in every state except WRITE. address_a and data_a hold their last values outside WRITE.
- **DONE** (exactly one cycle): done=1, busy=1, pixel_ready=0; next state IDLE.
  - start is ignored in DONE; a new load needs start high in IDLE.
- **start while busy** (LOAD, WRITE or DONE): ignored; base and counters are unchanged.
- **Latency and throughput:**
  - A word is written in the cycle after its last pixel is accepted.
  - Sustained throughput is 4 pixels per 5 cycles.
  - The done pulse comes 1 cycle after the final wren_a pulse.
- **Backpressure:** pixel_valid gaps in LOAD simply stall; there is no timeout.
- **Word count per frame:** ceil(FRAME_PIXELS/4) writes.
- **Counter width:** the pixel counter must be wide enough to reach FRAME_PIXELS with no overflow.

Test Plan:
1. FRAME_PIXELS=8, base=0x100, start pulse, then pixels 0x11..0x88 on consecutive cycles with valid held high → wren_a writes 0x44332211 @0x100 and 0x88776655 @0x101; done pulses one cycle after the second write; busy then falls; 2 writes total.
2. FRAME_PIXELS=6, base=0x20, pixels 0x11..0x66 → writes 0x44332211 @0x20 and 0x00006655 @0x21; exactly 2 wren_a pulses; done follows.
3. Backpressure: FRAME_PIXELS=8 with pixel_valid toggling 1/0 and random gaps → same data and addresses as scenario 1; pixel_ready=0 during each WRITE cycle; no pixel lost or duplicated.
4. start re-asserted with base=0x999 mid-load (LOAD and WRITE states), and pixel_valid=1 while IDLE → writes continue at the original base; pixels presented in IDLE are not consumed (pixel_ready=0).
5. Assert reset (0) asynchronously after 5 pixels of an 8-pixel frame → all outputs 0 immediately; no further wren_a; after release, a new start with base=0x40 produces writes from 0x40 with fresh lane 0 packing.
6. base=2^ADDR_WIDTH-1, FRAME_PIXELS=8 → first write at all-ones address, second write at address 0.

Source files
------------

// File: rtl/drom_writer_if.sv
// rtl/drom_writer_if.sv - pixel stream and port A write bus for the image memory writer
interface drom_writer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            pixel_in;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [31:0]           data_a;
  logic                  wren_a;

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    output pixel_ready,
    output address_a,
    output data_a,
    output wren_a
  );

  modport master (
    output pixel_in,
    output pixel_valid,
    input  pixel_ready,
    input  address_a,
    input  data_a,
    input  wren_a
  );
endinterface

// File: rtl/drom_writer.sv
// rtl/drom_writer.sv - packs 8-bit pixels into 32-bit words and writes one frame to port A
// Outputs are registered from the next state so they line up with the state they describe.
module drom_writer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FRAME_PIXELS = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  drom_writer_if.slave          pix_bus,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           pack_q, pack_d;
  logic [31:0]           data_q, data_d;
  logic                  ready_q, busy_q, wren_q, done_q;
  logic                  accept;
  logic [31:0]           pix_word;

  // ready_q is high exactly while in LOAD, so it also qualifies acceptance
  assign accept   = pix_bus.pixel_valid & ready_q;
  assign pix_word = {24'd0, pix_bus.pixel_in} << {lane_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_address;
          offset_d = '0;
          cnt_d    = '0;
          lane_d   = 2'd0;
          pack_d   = 32'd0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          pack_d = pack_q | pix_word;
          lane_d = lane_q + 2'd1;
          cnt_d  = cnt_q + CW'(1);
          if (lane_q == 2'd3 || cnt_d == LAST) begin
            state_d = WRITE;
            addr_d  = base_q + offset_q;
            data_d  = pack_d;
          end
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          pack_d   = 32'd0;
          lane_d   = 2'd0;
          offset_d = offset_q + ADDR_WIDTH'(1);
          state_d  = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      offset_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      lane_q   <= 2'd0;
      pack_q   <= 32'd0;
      data_q   <= 32'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      data_q   <= data_d;
      ready_q  <= (state_d == LOAD);
      busy_q   <= (state_d != IDLE);
      wren_q   <= (state_d == WRITE);
      done_q   <= (state_d == DONE);
    end
  end

  assign pix_bus.pixel_ready = ready_q;
  assign pix_bus.address_a   = addr_q;
  assign pix_bus.data_a      = data_q;
  assign pix_bus.wren_a      = wren_q;
  assign busy                = busy_q;
  assign done                = done_q;
endmodule

// File: tb/tb_drom_writer.sv
// tb/tb_drom_writer.sv - randomized bench for drom_writer against a frame-level write model
module tb_drom_writer;
  localparam int AW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start8, start6;
  logic [AW-1:0] base;
  logic [7:0]    pix;
  logic          pvalid;
  logic          busy8, done8, busy6, done6;

  always #5 clock = ~clock;

  drom_writer_if #(.ADDR_WIDTH(AW)) if8 ();
  drom_writer_if #(.ADDR_WIDTH(AW)) if6 ();

  assign if8.pixel_in    = pix;
  assign if8.pixel_valid = pvalid;
  assign if6.pixel_in    = pix;
  assign if6.pixel_valid = pvalid;

  drom_writer #(.ADDR_WIDTH(AW), .FRAME_PIXELS(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .base_address(base),
    .pix_bus(if8.slave), .busy(busy8), .done(done8)
  );

  drom_writer #(.ADDR_WIDTH(AW), .FRAME_PIXELS(6)) dut6 (
    .clock(clock), .reset(reset), .start(start6), .base_address(base),
    .pix_bus(if6.slave), .busy(busy6), .done(done6)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  wr_t        got8[$];
  wr_t        got6[$];
  wr_t        exp_q[$];
  logic [7:0] pq[$];
  int         dn8 = 0;
  int         dn6 = 0;
  logic       pw8 = 1'b0;
  logic       pw6 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (if8.wren_a) begin
      got8.push_back({if8.address_a, if8.data_a});
      check("ready_low_in_write8", 64'(if8.pixel_ready), 64'd0);
    end
    if (done8) begin
      dn8++;
      check("done_after_write8", 64'(pw8), 64'd1);
      check("busy_at_done8", 64'(busy8), 64'd1);
    end
    if (if6.wren_a) begin
      got6.push_back({if6.address_a, if6.data_a});
      check("ready_low_in_write6", 64'(if6.pixel_ready), 64'd0);
    end
    if (done6) begin
      dn6++;
      check("done_after_write6", 64'(pw6), 64'd1);
      check("busy_at_done6", 64'(busy6), 64'd1);
    end
    pw8 <= if8.wren_a;
    pw6 <= if6.wren_a;
  end

  // Frame model: pixel i lands in word i/4, byte lane i%4, at base + i/4 (mod 2^AW)
  task automatic build_exp(input logic [AW-1:0] b, input int n);
    logic [31:0] w;
    exp_q.delete();
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      w = w | (32'(pq[i]) << (8 * (i % 4)));
      if (i % 4 == 3 || i == n - 1) begin
        exp_q.push_back({AW'(b + AW'(i / 4)), w});
        w = 32'd0;
      end
    end
  endtask

  task automatic fill_fixed(input int n);
    pq.delete();
    for (int i = 0; i < n; i++) pq.push_back(8'((i + 1) * 8'h11));
  endtask

  task automatic fill_random(input int n);
    pq.delete();
    for (int i = 0; i < n; i++) pq.push_back(8'($urandom));
  endtask

  task automatic run_frame(input bit sel, input logic [AW-1:0] b, input bit gaps, input bit poke);
    int   n;
    int   idx;
    int   cyc;
    logic rdy;
    n = sel ? 6 : 8;
    got8.delete();
    got6.delete();
    dn8 = 0;
    dn6 = 0;
    build_exp(b, n);
    @(posedge clock); #1;
    base = b;
    if (sel) start6 = 1'b1; else start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    start6 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      pvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix    = pq[idx];
      if (poke) begin
        base = 32'h999;
        if (sel) start6 = 1'($urandom_range(0, 1)); else start8 = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      rdy = sel ? if6.pixel_ready : if8.pixel_ready;
      if (pvalid && rdy) idx++;
      @(posedge clock); #1;
      cyc++;
    end
    pvalid = 1'b0;
    start8 = 1'b0;
    start6 = 1'b0;
    check("pixels_accepted", 64'(idx), 64'(n));
    cyc = 0;
    while ((sel ? dn6 : dn8) == 0 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    repeat (3) @(negedge clock);
    if (sel) begin
      check("write_count", 64'(got6.size()), 64'(exp_q.size()));
      for (int i = 0; i < got6.size() && i < exp_q.size(); i++) begin
        check("write_addr", 64'(got6[i].a), 64'(exp_q[i].a));
        check("write_data", 64'(got6[i].d), 64'(exp_q[i].d));
      end
      check("done_count", 64'(dn6), 64'd1);
      check("busy_after", 64'(busy6), 64'd0);
      check("other_writes", 64'(got8.size()), 64'd0);
    end else begin
      check("write_count", 64'(got8.size()), 64'(exp_q.size()));
      for (int i = 0; i < got8.size() && i < exp_q.size(); i++) begin
        check("write_addr", 64'(got8[i].a), 64'(exp_q[i].a));
        check("write_data", 64'(got8[i].d), 64'(exp_q[i].d));
      end
      check("done_count", 64'(dn8), 64'd1);
      check("busy_after", 64'(busy8), 64'd0);
      check("other_writes", 64'(got6.size()), 64'd0);
    end
  endtask

  initial begin
    int idx;
    int cyc;
    reset  = 1'b0;
    start8 = 1'b0;
    start6 = 1'b0;
    base   = '0;
    pix    = 8'd0;
    pvalid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_wren", 64'(if8.wren_a), 64'd0);
    check("rst_addr", 64'(if8.address_a), 64'd0);
    check("rst_data", 64'(if8.data_a), 64'd0);
    check("rst_ready", 64'(if8.pixel_ready), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    reset = 1'b1;

    fill_fixed(8);
    run_frame(1'b0, 32'h100, 1'b0, 1'b0);
    fill_fixed(6);
    run_frame(1'b1, 32'h20, 1'b0, 1'b0);
    fill_fixed(8);
    run_frame(1'b0, 32'h100, 1'b1, 1'b0);

    // Pixels offered while idle must not be taken
    fill_fixed(8);
    pvalid = 1'b1;
    pix    = pq[0];
    repeat (3) begin
      @(negedge clock);
      check("idle_ready8", 64'(if8.pixel_ready), 64'd0);
      check("idle_ready6", 64'(if6.pixel_ready), 64'd0);
    end
    run_frame(1'b0, 32'h300, 1'b1, 1'b1);

    // Asynchronous reset after 5 of 8 pixels
    fill_fixed(8);
    got8.delete();
    @(posedge clock); #1;
    base   = 32'h100;
    start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 100) begin
      pvalid = 1'b1;
      pix    = pq[idx];
      @(negedge clock);
      if (if8.pixel_ready) idx++;
      @(posedge clock); #1;
      cyc++;
    end
    check("rst_pre_pixels", 64'(idx), 64'd5);
    #2 reset = 1'b0;
    #1;
    check("arst_wren", 64'(if8.wren_a), 64'd0);
    check("arst_addr", 64'(if8.address_a), 64'd0);
    check("arst_data", 64'(if8.data_a), 64'd0);
    check("arst_ready", 64'(if8.pixel_ready), 64'd0);
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    repeat (3) @(negedge clock);
    check("arst_write_count", 64'(got8.size()), 64'd1);
    if (got8.size() > 0) check("arst_first_word", 64'(got8[0]), {32'h100, 32'h44332211});
    pvalid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    fill_random(8);
    run_frame(1'b0, 32'h40, 1'b0, 1'b0);

    fill_random(8);
    run_frame(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      fill_random(s ? 6 : 8);
      run_frame(s, AW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
